// File: rtl/mfp_ahb_fabric_pkg.sv
// Shared types and legacy MIPSfpga memory map for the AHB-lite fabric.
`default_nettype none

package mfp_ahb_fabric_pkg;

   // Legacy map; bits 31:29 are ignored so kseg0/kseg1 aliases decode alike.
   localparam logic [31:0] BOOT_RAM_BASE = 32'h1FC0_0000;
   localparam logic [31:0] BOOT_RAM_MASK = 32'h1FC0_0000;
   localparam logic [31:0] PRG_RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] PRG_RAM_MASK  = 32'h1000_0000;
   localparam logic [31:0] GPIO_BASE     = 32'h1F80_0000;
   localparam logic [31:0] GPIO_MASK     = 32'h1FFF_FFF8;
   localparam logic [31:0] SEG_BASE      = 32'h1F70_0000;
   localparam logic [31:0] SEG_MASK      = 32'h1FF0_0000;
   localparam logic [31:0] IP_BASE       = 32'h1F80_000C;
   localparam logic [31:0] IP_MASK       = 32'h1FFF_FFFC;

   // Unused slots compare all-ones against a zero mask, so they never hit.
   localparam logic [32*8-1:0] LEGACY_BASE = {
      {3{32'hFFFF_FFFF}}, IP_BASE, SEG_BASE, GPIO_BASE, PRG_RAM_BASE, BOOT_RAM_BASE};
   localparam logic [32*8-1:0] LEGACY_MASK = {
      {3{32'h0000_0000}}, IP_MASK, SEG_MASK, GPIO_MASK, PRG_RAM_MASK, BOOT_RAM_MASK};

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mfp_ahb_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers plus error statistics.
`default_nettype none

module mfp_ahb_default_slave
   import mfp_ahb_fabric_pkg::*;
#(
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 accept_err,
   input  logic [31:0]          haddr,
   output logic                 ready,
   output logic                 resp,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [31:0]          err_addr
);

   ds_state_t state, state_next;

   always_ff @(posedge clk) begin
      if (rst) state <= DS_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      ready      = 1'b1;
      resp       = 1'b0;
      case (state)
         DS_IDLE: if (accept_err) state_next = DS_ERR1;
         DS_ERR1: begin
            ready      = 1'b0;
            resp       = 1'b1;
            state_next = DS_ERR2;
         end
         DS_ERR2: begin
            resp       = 1'b1;
            state_next = accept_err ? DS_ERR1 : DS_IDLE;
         end
         default: state_next = DS_IDLE;
      endcase
   end

   // Every accepted unmapped transfer is exactly one ERR1 entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
         err_addr  <= '0;
      end else if (accept_err) begin
         if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
         err_addr <= haddr;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mfp_ahb_fabric.sv
// AHB-lite single-master fabric: address decode, data-phase response mux and default slave.
`default_nettype none

module mfp_ahb_fabric
   import mfp_ahb_fabric_pkg::*;
#(
   parameter int                       N_SLAVES  = 5,
   parameter logic [N_SLAVES*32-1:0]   BASE_ADDR = LEGACY_BASE[N_SLAVES*32-1:0],
   parameter logic [N_SLAVES*32-1:0]   ADDR_MASK = LEGACY_MASK[N_SLAVES*32-1:0],
   parameter int                       ERR_CNT_W = 16
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic [31:0]            HADDR,
   input  logic [1:0]             HTRANS,
   output logic [N_SLAVES-1:0]    HSEL_S,
   input  logic [N_SLAVES*32-1:0] S_HRDATA,
   input  logic [N_SLAVES-1:0]    S_HREADYOUT,
   input  logic [N_SLAVES-1:0]    S_HRESP,
   output logic [31:0]            HRDATA,
   output logic                   HREADY,
   output logic                   HRESP,
   output logic [ERR_CNT_W-1:0]   ERR_COUNT,
   output logic [31:0]            ERR_ADDR
);

   logic [N_SLAVES-1:0] hit;
   logic [N_SLAVES-1:0] sel;
   logic                def_sel;
   logic                accept_err;
   logic [N_SLAVES:0]   dsel;          // bit N_SLAVES is the default slave
   logic [31:0]         rd_term [N_SLAVES];
   logic [31:0]         rdata;
   logic                def_ready;
   logic                def_resp;

   for (genvar i = 0; i < N_SLAVES; i++) begin : g_decode
      assign hit[i] = addr_hit(HADDR, BASE_ADDR[32*i +: 32], ADDR_MASK[32*i +: 32]);
   end

   // Lowest index wins among overlapping regions.
   always_comb begin
      logic lower;
      sel   = '0;
      lower = 1'b0;
      for (int i = 0; i < N_SLAVES; i++) begin
         sel[i] = hit[i] & ~lower;
         lower  = lower | hit[i];
      end
   end

   assign HSEL_S     = sel;
   assign def_sel    = ~|hit & HTRANS[1];
   assign accept_err = HREADY & def_sel;

   // IDLE/BUSY leaves the data phase empty so the fabric answers OKAY itself.
   always_ff @(posedge HCLK) begin
      if (HRESET)      dsel <= '0;
      else if (HREADY) dsel <= {def_sel, sel & {N_SLAVES{HTRANS[1]}}};
   end

   for (genvar i = 0; i < N_SLAVES; i++) begin : g_rdmux
      assign rd_term[i] = S_HRDATA[32*i +: 32] & {32{dsel[i]}};
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < N_SLAVES; i++) rdata = rdata | rd_term[i];
   end

   assign HRDATA = rdata;
   assign HREADY = ~|dsel
                 | |(dsel[N_SLAVES-1:0] & S_HREADYOUT)
                 | (dsel[N_SLAVES] & def_ready);
   assign HRESP  = |(dsel[N_SLAVES-1:0] & S_HRESP)
                 | (dsel[N_SLAVES] & def_resp);

   mfp_ahb_default_slave #(
      .ERR_CNT_W (ERR_CNT_W)
   ) u_default_slave (
      .clk        (HCLK),
      .rst        (HRESET),
      .accept_err (accept_err),
      .haddr      (HADDR),
      .ready      (def_ready),
      .resp       (def_resp),
      .err_count  (ERR_COUNT),
      .err_addr   (ERR_ADDR)
   );

endmodule

`default_nettype wire

// File: tb/tb_mfp_ahb_fabric.sv
// Directed bench for mfp_ahb_fabric with a queue of expected observations.
`default_nettype none

module tb_mfp_ahb_fabric;

   localparam int NS = 5;
   localparam int CW = 2;
   // s1 and s3 overlap on 0x20xxxxxx; s0/s2/s4 follow the legacy boot/GPIO/segment map.
   localparam logic [NS*32-1:0] TB_BASE = {32'h1F70_0000, 32'h2000_0000, 32'h1F80_0000,
                                           32'h2000_0000, 32'h1FC0_0000};
   localparam logic [NS*32-1:0] TB_MASK = {32'h1FF0_0000, 32'hFF00_0000, 32'h1FFF_FFF8,
                                           32'hF000_0000, 32'h1FC0_0000};

   logic             HCLK = 1'b0;
   logic             HRESET;
   logic [31:0]      HADDR;
   logic [1:0]       HTRANS;
   logic [NS-1:0]    HSEL_S;
   logic [NS*32-1:0] S_HRDATA;
   logic [NS-1:0]    S_HREADYOUT;
   logic [NS-1:0]    S_HRESP;
   logic [31:0]      HRDATA;
   logic             HREADY;
   logic             HRESP;
   logic [CW-1:0]    ERR_COUNT;
   logic [31:0]      ERR_ADDR;

   mfp_ahb_fabric #(
      .N_SLAVES  (NS),
      .BASE_ADDR (TB_BASE),
      .ADDR_MASK (TB_MASK),
      .ERR_CNT_W (CW)
   ) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL_S      (HSEL_S),
      .S_HRDATA    (S_HRDATA),
      .S_HREADYOUT (S_HREADYOUT),
      .S_HRESP     (S_HRESP),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .ERR_COUNT   (ERR_COUNT),
      .ERR_ADDR    (ERR_ADDR)
   );

   always #5 HCLK = ~HCLK;

   typedef enum int {F_HSEL, F_RDATA, F_READY, F_RESP, F_CNT, F_EADDR} field_t;
   typedef struct {
      string       tag;
      field_t      field;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   failed = 0;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;

   task automatic push_exp(input string tag, input field_t f, input logic [31:0] v);
      exp_t e;
      e.tag   = tag;
      e.field = f;
      e.val   = v;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input field_t f);
      case (f)
         F_HSEL:  return 32'(HSEL_S);
         F_RDATA: return HRDATA;
         F_READY: return 32'(HREADY);
         F_RESP:  return 32'(HRESP);
         F_CNT:   return 32'(ERR_COUNT);
         default: return ERR_ADDR;
      endcase
   endfunction

   task automatic check();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.field);
         tests++;
         assert (obs === e.val) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [1:0] t);
      HADDR  = a;
      HTRANS = t;
   endtask

   task automatic exp_resp(input string tag, input logic rdy, input logic rsp);
      push_exp({tag, "_hready"}, F_READY, 32'(rdy));
      push_exp({tag, "_hresp"},  F_RESP,  32'(rsp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      HRESET      = 1'b1;
      drive(32'h0, IDLE);
      S_HREADYOUT = '1;
      S_HRESP     = '0;
      S_HRDATA    = {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hDEAD_BEEF};
      tick();
      tick();
      HRESET = 1'b0;

      exp_resp("reset", 1'b1, 1'b0);
      push_exp("reset_hrdata", F_RDATA, 32'h0);
      push_exp("reset_cnt",    F_CNT,   32'h0);
      push_exp("reset_eaddr",  F_EADDR, 32'h0);
      check();

      // Simple read from slave 0
      drive(32'h1FC0_0010, NONSEQ);
      push_exp("rd0_hsel", F_HSEL, 32'h01);
      check();
      tick();
      drive(32'h0, IDLE);
      push_exp("rd0_hrdata", F_RDATA, 32'hDEAD_BEEF);
      exp_resp("rd0", 1'b1, 1'b0);
      check();
      tick();

      // Overlap: slaves 1 and 3 both hit, lowest wins
      drive(32'h2000_1234, NONSEQ);
      push_exp("ovl_hsel", F_HSEL, 32'h02);
      check();
      tick();
      drive(32'h0, IDLE);
      push_exp("ovl_hrdata", F_RDATA, 32'hA000_0001);
      check();
      tick();

      // Slave 2 wait states with a pipelined address to slave 0
      drive(32'h1F80_0000, NONSEQ);
      push_exp("ws_hsel_s2", F_HSEL, 32'h04);
      check();
      tick();
      drive(32'h1FC0_0000, NONSEQ);
      S_HREADYOUT[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         push_exp("ws_hready_low", F_READY, 32'h0);
         push_exp("ws_hrdata_held", F_RDATA, 32'hA000_0002);
         push_exp("ws_hsel_follows", F_HSEL, 32'h01);
         check();
         tick();
      end
      S_HREADYOUT[2] = 1'b1;
      push_exp("ws_release_hready", F_READY, 32'h1);
      push_exp("ws_release_hrdata", F_RDATA, 32'hA000_0002);
      check();
      tick();
      drive(32'h0, IDLE);
      push_exp("ws_next_hrdata", F_RDATA, 32'hDEAD_BEEF);
      check();
      tick();

      // IDLE and BUSY to unmapped addresses are zero-wait OKAY
      drive(32'h1234_5678, IDLE);
      tick();
      drive(32'h1234_5678, BUSY);
      exp_resp("idle_unmapped", 1'b1, 1'b0);
      push_exp("idle_unmapped_cnt", F_CNT, 32'h0);
      check();
      tick();
      exp_resp("busy_unmapped", 1'b1, 1'b0);
      push_exp("busy_unmapped_cnt", F_CNT, 32'h0);
      check();

      // Single unmapped NONSEQ
      drive(32'h1234_5678, NONSEQ);
      push_exp("err_hsel", F_HSEL, 32'h0);
      check();
      tick();
      drive(32'h0, IDLE);
      exp_resp("err1", 1'b0, 1'b1);
      push_exp("err1_cnt",   F_CNT,   32'h1);
      push_exp("err1_eaddr", F_EADDR, 32'h1234_5678);
      check();
      tick();
      exp_resp("err2", 1'b1, 1'b1);
      check();
      tick();
      exp_resp("err_done", 1'b1, 1'b0);
      push_exp("err_done_hrdata", F_RDATA, 32'h0);
      push_exp("err_done_cnt", F_CNT, 32'h1);
      check();

      // Back-to-back unmapped NONSEQs with counter saturation
      drive(32'h4000_0000, NONSEQ);
      tick();
      drive(32'h5000_0000, NONSEQ);
      exp_resp("b2b_a_err1", 1'b0, 1'b1);
      push_exp("b2b_a_cnt",   F_CNT,   32'h2);
      push_exp("b2b_a_eaddr", F_EADDR, 32'h4000_0000);
      check();
      tick();
      exp_resp("b2b_a_err2", 1'b1, 1'b1);
      check();
      tick();
      drive(32'h6000_0000, NONSEQ);
      exp_resp("b2b_b_err1", 1'b0, 1'b1);
      push_exp("b2b_b_cnt",   F_CNT,   32'h3);
      push_exp("b2b_b_eaddr", F_EADDR, 32'h5000_0000);
      check();
      tick();
      exp_resp("b2b_b_err2", 1'b1, 1'b1);
      check();
      tick();
      drive(32'h7000_0000, NONSEQ);
      push_exp("sat_c_cnt",   F_CNT,   32'h3);
      push_exp("sat_c_eaddr", F_EADDR, 32'h6000_0000);
      check();
      tick();
      exp_resp("sat_c_err2", 1'b1, 1'b1);
      check();
      tick();
      exp_resp("sat_d_err1", 1'b0, 1'b1);
      push_exp("sat_d_cnt",   F_CNT,   32'h3);
      push_exp("sat_d_eaddr", F_EADDR, 32'h7000_0000);
      check();

      // Reset while in ERR1
      HRESET = 1'b1;
      drive(32'h0, IDLE);
      tick();
      HRESET = 1'b0;
      exp_resp("rst_err1", 1'b1, 1'b0);
      push_exp("rst_err1_hrdata", F_RDATA, 32'h0);
      push_exp("rst_err1_cnt",    F_CNT,   32'h0);
      push_exp("rst_err1_eaddr",  F_EADDR, 32'h0);
      check();

      // Reset while a slave is stalling
      drive(32'h1F80_0000, NONSEQ);
      tick();
      drive(32'h0, IDLE);
      S_HREADYOUT[2] = 1'b0;
      push_exp("stall_hready", F_READY, 32'h0);
      check();
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      exp_resp("rst_stall", 1'b1, 1'b0);
      push_exp("rst_stall_hrdata", F_RDATA, 32'h0);
      check();
      S_HREADYOUT[2] = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
